// File: rtl/alt_vipvfr131_common_sync_stable.sv
// Multi-stage synchroniser with a whole-vector stability filter and change/edge strobes.
// Define ALT_VIPVFR131_SYNC_EDGE_EN to build the per-bit rise/fall pulse registers.
module alt_vipvfr131_common_sync_stable #(
  parameter int               WIDTH           = 1,
  parameter int               STAGES          = 2,
  parameter int               CLOCKS_ARE_SAME = 0,
  parameter int               STABLE_CYCLES   = 0,
  parameter logic [WIDTH-1:0] RESET_VALUE     = {WIDTH{1'b0}}
) (
  input  logic             sync_clock,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             data_changed,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  localparam int CNT_W = (STABLE_CYCLES > 0) ? $clog2(STABLE_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

  logic [WIDTH-1:0] chain_out_s;
  logic [WIDTH-1:0] cand_r;
  logic [CNT_W-1:0] cnt_r;
  logic [WIDTH-1:0] data_out_r;
  logic             data_changed_r;
  logic             update_s;

  generate
    if (CLOCKS_ARE_SAME != 0) begin : g_bypass
      assign chain_out_s = data_in;
    end else begin : g_sync
      (* altera_attribute = "-name SYNCHRONIZER_IDENTIFICATION FORCED_IF_ASYNCHRONOUS; -name CUT ON -from *; -name DONT_MERGE_REGISTER ON; -name PRESERVE_REGISTER ON" *)
      logic [STAGES-1:0][WIDTH-1:0] sync_r;

      // Synchroniser chain; element 0 is the metastability-exposed capture flop
      always_ff @(posedge sync_clock) begin
        if (rst) begin
          sync_r <= {STAGES{RESET_VALUE}};
        end else begin
          sync_r <= {sync_r[STAGES-2:0], data_in};
        end
      end

      assign chain_out_s = sync_r[STAGES-1];
    end
  endgenerate

  // Forward the candidate once it has been held long enough and differs from the output
  always_comb begin
    update_s = 1'b0;
    if ((cnt_r == CNT_MAX) && (cand_r != data_out_r)) begin
      update_s = 1'b1;
    end else begin
      update_s = 1'b0;
    end
  end

  // Stability filter: any bit change restarts qualification; update uses the pre-edge candidate
  always_ff @(posedge sync_clock) begin
    if (rst) begin
      cand_r         <= RESET_VALUE;
      cnt_r          <= {CNT_W{1'b0}};
      data_out_r     <= RESET_VALUE;
      data_changed_r <= 1'b0;
    end else begin
      if (chain_out_s != cand_r) begin
        cand_r <= chain_out_s;
        cnt_r  <= {CNT_W{1'b0}};
      end else if (cnt_r < CNT_MAX) begin
        cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        cnt_r <= cnt_r;
      end
      if (update_s) begin
        data_out_r     <= cand_r;
        data_changed_r <= 1'b1;
      end else begin
        data_changed_r <= 1'b0;
      end
    end
  end

  assign data_out     = data_out_r;
  assign data_changed = data_changed_r;

`ifdef ALT_VIPVFR131_SYNC_EDGE_EN
  logic [WIDTH-1:0] rise_r;
  logic [WIDTH-1:0] fall_r;

  // Per-bit edge pulses, coincident with the data_out update
  always_ff @(posedge sync_clock) begin
    if (rst) begin
      rise_r <= {WIDTH{1'b0}};
      fall_r <= {WIDTH{1'b0}};
    end else if (update_s) begin
      rise_r <= cand_r & ~data_out_r;
      fall_r <= ~cand_r & data_out_r;
    end else begin
      rise_r <= {WIDTH{1'b0}};
      fall_r <= {WIDTH{1'b0}};
    end
  end

  assign rise = rise_r;
  assign fall = fall_r;
`else
  assign rise = {WIDTH{1'b0}};
  assign fall = {WIDTH{1'b0}};
`endif

endmodule

// File: doc/alt_vipvfr131_common_sync_stable.md
# alt_vipvfr131_common_sync_stable

Parametrised multi-stage synchroniser with a stability (glitch) filter and edge-pulse outputs, for bringing slow quasi-static control/status vectors (mode bits, enables, status flags) from a foreign clock domain into the frame reader's `sync_clock` domain. Generalises the plain two-flop synchroniser: configurable chain depth, optional same-clock bypass, a qualifier that only forwards a value once it has been stable for a set number of cycles, and per-bit rise/fall plus whole-vector change strobes.

## Interface
- `WIDTH`, 1: vector width, ≥1.
- `STAGES`, 2: synchroniser flop count, ≥2; ignored when `CLOCKS_ARE_SAME`=1.
- `CLOCKS_ARE_SAME`, 0: 1 = no sync flops; the filter input is `data_in` directly.
- `STABLE_CYCLES`, 0: extra cycles a new value must hold before forwarding; 0 = no filtering.
- `RESET_VALUE`, 0: `WIDTH`-bit reset value of sync flops, candidate and `data_out`.

Clocking: one clock; reset is synchronous and active-high.
- `sync_clock`  in  1  destination-domain clock.
- `rst`  in  1  synchronous, active-high reset.
- `data_in`  in  WIDTH  asynchronous (or same-clock) input vector.
- `data_out`  out  WIDTH  synchronised, filtered vector.
- `data_changed`  out  1  one-cycle strobe on every `data_out` update.
- `rise`  out  WIDTH  per-bit one-cycle pulse, bit went 0→1 in `data_out`.
- `fall`  out  WIDTH  per-bit one-cycle pulse, bit went 1→0 in `data_out`.

## Operation
- Sync chain `s[1..STAGES]`: `s[1]<=data_in`, `s[k]<=s[k-1]`; chain output S = `s[STAGES]`, or `data_in` when bypassed. Keep existing false-path/synchroniser attributes on `s[1]` and the chain.
- Candidate register `cand` (WIDTH), counter `cnt` (width clog2(STABLE_CYCLES+1), min 1).
- Each edge, not in reset:
  - S≠cand: `cand<=S`, `cnt<=0`.
  - S=cand and cnt<STABLE_CYCLES: `cnt<=cnt+1`.
  - Else hold; cnt saturates at STABLE_CYCLES, never wraps.
- Update, evaluated on current-cycle values: cnt=STABLE_CYCLES and cand≠data_out → `data_out<=cand`, `data_changed<=1`, `rise<=cand&~data_out`, `fall<=~cand&data_out`. Otherwise strobes/pulses <=0.
- Simultaneous: S changes on the same edge an update fires → update uses the old cand; new value restarts qualification (cnt=0).
- Filter acts on the whole vector: any bit change restarts qualification for all bits.
- Reset: all `s[k]`, cand, `data_out` <= RESET_VALUE; cnt<=0; `data_changed`, `rise`, `fall` <=0. Reset mid-qualification discards the candidate; no pulse produced for it.

## Timing
- Reset value of every output: `data_out`=RESET_VALUE, `data_changed`=0, `rise`=0, `fall`=0.
- `data_in` stable before edge 1 → S valid after edge STAGES → cand after STAGES+1 → `data_out`/strobes after edge STAGES+2+STABLE_CYCLES (bypass: 2+STABLE_CYCLES).
- Defaults (STAGES=2, N=0): latency 4 edges; every change at S forwarded, including single-cycle values.
- A value at S is forwarded iff held ≥STABLE_CYCLES+1 consecutive cycles; shorter glitches produce no `data_out` change and no strobe.
- Strobes are exactly one cycle, coincident with the `data_out` change; back-to-back updates possible only when STABLE_CYCLES=0.

## Configuration
- `ALT_VIPVFR131_SYNC_EDGE_EN` defined: `rise`/`fall` registers built as above.
- Undefined: `rise`/`fall` driven constant 0, no registers inferred; `data_out`, `data_changed` unchanged.

## Test plan
- Reset: WIDTH=8, RESET_VALUE=8'hA5, `rst` high 3 cycles → `data_out`=8'hA5, all strobes 0, no strobe on release with `data_in`=8'hA5.
- Latency: defaults, `data_in` 0→1 before edge 1 → `data_out`=1, `data_changed`=1, `rise`=1 after edge 4, all strobes 0 after edge 5.
- Glitch reject: STABLE_CYCLES=3, 3-cycle pulse at `data_in` → no change; 4-cycle pulse → `data_out` follows after edge STAGES+5, then returns with `fall`.
- Simultaneous: STABLE_CYCLES=0, `data_in` 8'h01, 8'h02, 8'h03 on consecutive cycles → three consecutive `data_changed` pulses, `rise`/`fall` per bit correct.
- Bypass: CLOCKS_ARE_SAME=1, STAGES=5 → latency 2 edges.
- Reset mid-qualification: STABLE_CYCLES=4, assert `rst` at cnt=2 → `data_out`=RESET_VALUE, no strobe; macro off → `rise`/`fall` stay 0 throughout.
